// File: rtl/seg_scan_mux.sv
// Purpose   : time-multiplexes four 8-bit segment patterns onto one common-anode
//             4-digit 7-segment module, with per-slot blanking and optional blink.
// Latency   : outputs registered, aligned with cnt/digit_idx (no extra lag cycle);
//             new input patterns appear at the next frame boundary.
// Backpress : none, free-running scanner; inputs are sampled, never acknowledged.
//
// Ports:
//   clk        system clock
//   clear      synchronous reset, active-low
//   seg0..seg3 digit patterns (seg0 = rightmost digit)
//   blink_en   1 = blink the whole display
//   seg_out    shared segment lines
//   an_out     anode enables, bit i = digit i
//   digit_idx  digit slot currently scanned
//   frame_tick 1-cycle pulse in the first cycle of every frame
module seg_scan_mux #(
    parameter int           DIGIT_TICKS   = 12500,
    parameter int           BLANK_TICKS   = 500,
    parameter int           BLINK_FRAMES  = 256,
    parameter logic [7:0]   SEG_OFF       = 8'hFF,
    parameter bit           AN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] seg0,
    input  logic [7:0] seg1,
    input  logic [7:0] seg2,
    input  logic [7:0] seg3,
    input  logic       blink_en,
    output logic [7:0] seg_out,
    output logic [3:0] an_out,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int CW = (DIGIT_TICKS  > 1) ? $clog2(DIGIT_TICKS)  : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx_nx;
    logic [7:0]    shadow    [4];
    logic [7:0]    shadow_nx [4];
    logic [7:0]    seg_in    [4];
    logic          load_pending;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          blink_phase, blink_phase_nx;

    logic          last_slot;
    logic          frame_wrap;
    logic          load;
    logic          dark;
    logic [3:0]    an_sel;
    logic [3:0]    an_nx;
    logic [7:0]    seg_nx;

    always_comb begin
        seg_in[0] = seg0;
        seg_in[1] = seg1;
        seg_in[2] = seg2;
        seg_in[3] = seg3;

        last_slot  = (int'(cnt) == DIGIT_TICKS - 1);
        cnt_nx     = last_slot ? '0 : cnt + 1'b1;
        idx_nx     = last_slot ? digit_idx + 2'd1 : digit_idx;
        frame_wrap = last_slot && (digit_idx == 2'd3);

        // Shadows only change at a frame boundary (or right after reset),
        // so a digit can never tear mid-frame.
        load = load_pending || frame_wrap;
        for (int i = 0; i < 4; i++) begin
            shadow_nx[i] = load ? seg_in[i] : shadow[i];
        end

        blink_cnt_nx   = blink_cnt;
        blink_phase_nx = blink_phase;
        if (!blink_en) begin
            blink_cnt_nx   = '0;
            blink_phase_nx = 1'b0;
        end else if (frame_wrap) begin
            if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
                blink_cnt_nx   = '0;
                blink_phase_nx = ~blink_phase;
            end else begin
                blink_cnt_nx = blink_cnt + 1'b1;
            end
        end

        // Decode from next-state values so the registered outputs line up
        // with the counters in the same cycle.
        dark   = (int'(cnt_nx) < BLANK_TICKS) || blink_phase_nx;
        an_sel = 4'b0001 << idx_nx;
        an_nx  = dark ? AN_OFF : (AN_ACTIVE_LOW ? ~an_sel : an_sel);
        seg_nx = dark ? SEG_OFF : shadow_nx[idx_nx];
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            cnt          <= '0;
            digit_idx    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= SEG_OFF;
            end
            load_pending <= 1'b1;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            an_out       <= AN_OFF;
            seg_out      <= SEG_OFF;
            frame_tick   <= 1'b0;
        end else begin
            cnt          <= cnt_nx;
            digit_idx    <= idx_nx;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= shadow_nx[i];
            end
            load_pending <= 1'b0;
            blink_cnt    <= blink_cnt_nx;
            blink_phase  <= blink_phase_nx;
            an_out       <= an_nx;
            seg_out      <= seg_nx;
            frame_tick   <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: one instance with a 2-cycle blank and one with no
// blank, both driven by the same stimulus and checked every cycle against a
// model derived from elapsed time since reset release.
module tb_seg_scan_mux;

    localparam int DT = 8;
    localparam int FR = 4 * DT;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] seg0 = 8'h00, seg1 = 8'h00, seg2 = 8'h00, seg3 = 8'h00;
    logic       blink_en = 1'b0;

    logic [7:0] so_a, so_b;
    logic [3:0] an_a, an_b;
    logic [1:0] di_a, di_b;
    logic       ft_a, ft_b;

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, frame boundaries seen while
    // blink is enabled, and the patterns captured at the last load.
    int         t  = 0;
    int         nb = 0;
    logic [7:0] snap [4];

    always #5 clk = ~clk;

    seg_scan_mux #(
        .DIGIT_TICKS(DT), .BLANK_TICKS(2), .BLINK_FRAMES(BF),
        .SEG_OFF(8'hFF), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .clear(clear),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .blink_en(blink_en),
        .seg_out(so_a), .an_out(an_a), .digit_idx(di_a), .frame_tick(ft_a)
    );

    seg_scan_mux #(
        .DIGIT_TICKS(DT), .BLANK_TICKS(0), .BLINK_FRAMES(BF),
        .SEG_OFF(8'hFF), .AN_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .clear(clear),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .blink_en(blink_en),
        .seg_out(so_b), .an_out(an_b), .digit_idx(di_b), .frame_tick(ft_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic void exp_out(input int blank,
                                    output logic [7:0] s, output logic [3:0] a,
                                    output logic [1:0] d, output logic f);
        int         pos;
        logic       dk;
        logic [3:0] oh;
        pos = t % FR;
        d   = 2'(pos / DT);
        f   = (t > 0) && (pos == 0);
        dk  = (t == 0) || ((pos % DT) < blank) || (((nb / BF) % 2) == 1);
        oh  = 4'b0001 << (pos / DT);
        s   = dk ? 8'hFF : snap[pos / DT];
        a   = dk ? 4'hF : ~oh;
    endfunction

    task automatic step();
        logic [7:0] es;
        logic [3:0] ea;
        logic [1:0] ed;
        logic       ef;
        @(posedge clk);
        if (!clear) begin
            t  = 0;
            nb = 0;
        end else begin
            t++;
            if (t == 1 || (t % FR) == 0) snap = '{seg0, seg1, seg2, seg3};
            if (!blink_en) nb = 0;
            else if ((t % FR) == 0) nb++;
        end
        #1;
        exp_out(2, es, ea, ed, ef);
        chk("seg_out",    so_a, es);
        chk("an_out",     {4'h0, an_a}, {4'h0, ea});
        chk("digit_idx",  {6'h0, di_a}, {6'h0, ed});
        chk("frame_tick", {7'h0, ft_a}, {7'h0, ef});
        exp_out(0, es, ea, ed, ef);
        chk("nb_seg_out",    so_b, es);
        chk("nb_an_out",     {4'h0, an_b}, {4'h0, ea});
        chk("nb_digit_idx",  {6'h0, di_b}, {6'h0, ed});
        chk("nb_frame_tick", {7'h0, ft_b}, {7'h0, ef});
    endtask

    initial begin
        // Reset hold with arbitrary inputs.
        clear = 1'b0;
        repeat (5) begin
            seg0 = 8'($urandom); seg1 = 8'($urandom);
            seg2 = 8'($urandom); seg3 = 8'($urandom);
            blink_en = 1'($urandom);
            step();
        end

        // Release and scan two full frames.
        seg0 = 8'hC0; seg1 = 8'hF9; seg2 = 8'hA4; seg3 = 8'hB0;
        blink_en = 1'b0;
        clear = 1'b1;
        repeat (2 * FR + 6) step();

        // Mid-frame update while digit 2 is scanned.
        while (((t % FR) / DT) != 2) step();
        seg0 = 8'h80;
        repeat (2 * FR) step();

        // Blink from a frame start, then drop it during a dark frame.
        while ((t % FR) != 0) step();
        blink_en = 1'b1;
        repeat (6 * FR + 8) step();
        blink_en = 1'b0;
        repeat (FR) step();

        // Reset mid-scan at digit 2, slot count 5.
        while ((t % FR) != 2 * DT + 5) step();
        seg0 = 8'h99; seg1 = 8'h92; seg2 = 8'h82; seg3 = 8'hF8;
        clear = 1'b0;
        step();
        clear = 1'b1;
        repeat (2 * FR + 6) step();

        // Randomised tail: pattern changes, blink toggles, occasional reset.
        repeat (800) begin
            if ($urandom_range(0, 9) == 0) begin
                seg0 = 8'($urandom); seg1 = 8'($urandom);
                seg2 = 8'($urandom); seg3 = 8'($urandom);
            end
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
            clear = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream display stage after the top level. Consumes the four encoded 8-bit segment patterns (LED0..LED3) and drives one time-multiplexed 4-digit common-anode 7-segment module.
- Uses shared segment lines plus four anode enables.
- Samples the patterns once per frame, so a digit never changes mid-frame (no tearing).
- Inserts a blanking interval at every digit switch to suppress ghosting.
- Provides an optional blink mode, driven by Done_out.

Parameters:
- DIGIT_TICKS, 12500: clk cycles per digit slot (50 MHz gives a 1 kHz frame).
- BLANK_TICKS, 500: leading cycles of each slot with anodes off. Must satisfy 0 <= BLANK_TICKS < DIGIT_TICKS.
- BLINK_FRAMES, 256: frames per blink half-period.
- SEG_OFF, 8'hFF: segment pattern driven when the display is dark.
- AN_ACTIVE_LOW, 1: 1 means anode enables are active-low.

Ports:
- clk  in  1  system clock
- clear  in  1  synchronous reset, active-low
- seg0  in  8  digit 0 pattern (rightmost)
- seg1  in  8  digit 1 pattern
- seg2  in  8  digit 2 pattern
- seg3  in  8  digit 3 pattern (leftmost)
- blink_en  in  1  1 = blink whole display
- seg_out  out  8  shared segment lines
- an_out  out  4  anode enables; bit i = digit i
- digit_idx  out  2  digit slot currently scanned
- frame_tick  out  1  1-cycle pulse at each frame boundary

Behaviour:
- State:
  - slot counter cnt, range 0..DIGIT_TICKS-1
  - digit_idx, range 0..3
  - four 8-bit shadow registers
  - load_pending flag
  - blink frame counter and blink_phase bit
- Outputs:
  - All outputs are registered.
  - seg_out and an_out are computed from next-state values, so they always match the current cnt and digit_idx (no extra cycle of lag).
- Reset (clear=0 at an edge):
  - cnt=0, digit_idx=0, shadows=SEG_OFF, load_pending=1, blink counter=0, blink_phase=0.
  - an_out = all off (4'hF when AN_ACTIVE_LOW), seg_out=SEG_OFF, frame_tick=0.
  - Reset mid-scan takes effect at that edge, regardless of state.
- Counting (each edge with clear=1):
  - cnt increments.
  - At cnt=DIGIT_TICKS-1, cnt wraps to 0 and digit_idx increments mod 4.
- Shadow load (all four simultaneously):
  - on the first edge with clear=1 after reset (clears load_pending), and
  - on every edge where digit_idx wraps 3->0.
  - Input changes at any other time are not visible until the next load.
- frame_tick:
  - =1 exactly in the cycle after a 3->0 wrap (cnt=0, digit_idx=0).
  - Not asserted on reset release.
- Display decode, dark condition = (cnt < BLANK_TICKS) OR blink_phase=1:
  - Dark: an_out all off, seg_out=SEG_OFF.
  - Otherwise: an_out = one-hot(digit_idx), inverted if AN_ACTIVE_LOW; seg_out = shadow[digit_idx].
  - BLANK_TICKS=0: anodes switch directly between digits with no dark cycle.
- Blink:
  - blink_en=0: the next edge forces blink_phase=0 and blink counter=0.
  - blink_en=1: the counter increments on each frame boundary (the edge producing frame_tick). On reaching BLINK_FRAMES it resets to 0 and toggles blink_phase.
  - Blink dark overrides everything; the scan counters keep running.
- Timing: frame period = 4*DIGIT_TICKS cycles. Duty per digit = (DIGIT_TICKS-BLANK_TICKS)/(4*DIGIT_TICKS).
- Inputs are assumed synchronous to clk. No handshake; the block free-runs.

Test Plan:
Bench parameters throughout: DIGIT_TICKS=8, BLANK_TICKS=2, BLINK_FRAMES=2, AN_ACTIVE_LOW=1, SEG_OFF=8'hFF.
1. Reset hold: clear=0 for 5 cycles with arbitrary inputs.
   -> Every cycle: an_out=4'hF, seg_out=8'hFF, digit_idx=0, frame_tick=0.
2. Release scan: seg0..3=C0,F9,A4,B0; then clear=1.
   -> 2 dark cycles.
   -> an_out=1110, seg_out=C0 for 6 cycles.
   -> 2 dark; an_out=1101, seg_out=F9 for 6; then 1011/A4; then 0111/B0.
   -> frame_tick pulses once 32 cycles after release; pattern repeats with period 32.
3. Mid-frame update: change seg0 to 8'h80 while digit_idx=2.
   -> Remainder of frame unchanged.
   -> After the next frame_tick, digit 0 shows 80; digits 1-3 unchanged.
4. Blink: raise blink_en at a frame start.
   -> 2 normal frames, then 2 frames fully dark (an_out=F, seg_out=FF), alternating.
   -> Dropping blink_en during a dark frame restores normal decode from the next cycle.
   -> digit_idx keeps sequencing throughout.
5. Reset mid-operation: clear=0 at digit_idx=2, cnt=5.
   -> Next cycle: all off, digit_idx=0.
   -> After release, the scan restarts exactly as in scenario 2, with freshly loaded shadows.
6. BLANK_TICKS=0 build, inputs as in scenario 2.
   -> an_out goes 1110 -> 1101 -> 1011 -> 0111, 8 cycles each, with no all-off cycle.
   -> seg_out changes in the same cycle as an_out.
